ring_sequence_checker: RTL and testbench
========================================

Name: ring_sequence_checker

Overview:
- Receive-side monitor for a one-hot ring counter bus. The ring bus shifts each clock as q0<-q(W-1), q1<-q0, and so on; its reset pattern is ...0001.
- Each enabled sample is validated as one-hot and decoded to a binary index.
- Checks that each sample is the left-rotation of the previous one. Acquires lock after a run of correct rotations; drops lock after consecutive misses.
- Sits downstream of any ring-counter sequencer as its sequence checker, error counter and one-hot-to-binary decoder.

Parameters:
- WIDTH, 4, ring width in bits (>=2).
- LOCK_COUNT, 3, consecutive correct rotations needed to enter LOCKED (>=1).
- UNLOCK_COUNT, 2, consecutive misses in LOCKED that return the block to HUNT (>=1).
- ERR_CNT_W, 8, error counter width.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- en  input  1  sample enable; state advances only when en=1.
- ring_in  input  WIDTH  ring bus sample.
- index  output  $clog2(WIDTH)  binary position of the set bit in the last sample.
- onehot_ok  output  1  last sample had exactly one bit set.
- seq_ok  output  1  last sample equalled rotl(prev) and prev was valid.
- locked  output  1  FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse per miss while LOCKED.
- err_count  output  ERR_CNT_W  saturating count of LOCKED misses.

Behaviour:
- Reset, with rst sampled high at posedge:
  - All outputs are 0.
  - State = HUNT; prev = 0; good_cnt = 0; miss_cnt = 0.
  - rst has priority over en.
- Latency: all outputs are registered. A sample taken at edge N is reflected on the outputs after edge N.
- Definitions:
  - rotl(x) = {x[WIDTH-2:0], x[WIDTH-1]}.
  - valid = popcount(ring_in)==1.
  - match = valid && has_prev && ring_in==rotl(prev), where has_prev = (state!=HUNT).
- Decode on every en=1 edge:
  - index <= valid ? position of the set bit : 0.
  - onehot_ok <= valid.
  - seq_ok <= match.
- en=0: all state and outputs except err_pulse are held; err_pulse <= 0.
- err_pulse is 0 on every edge where no LOCKED miss occurs.
- FSM transitions, evaluated only when en=1:
  - HUNT:
    - valid -> ACQUIRE, prev <= ring_in, good_cnt <= 0.
    - Otherwise stay in HUNT.
  - ACQUIRE:
    - match: good_cnt+1; if good_cnt+1==LOCK_COUNT -> LOCKED with miss_cnt <= 0. prev <= ring_in.
    - valid && !match: stay in ACQUIRE, good_cnt <= 0, prev <= ring_in (restart acquisition).
    - !valid -> HUNT.
    - No errors are counted in ACQUIRE.
  - LOCKED:
    - match: miss_cnt <= 0, prev <= ring_in.
    - Miss (!match):
      - err_pulse <= 1.
      - err_count <= err_count+1, saturating at all-ones.
      - miss_cnt+1.
      - prev <= valid ? ring_in : rotl(prev). The invalid-sample path is a flywheel: the expected sequence keeps advancing.
      - if miss_cnt+1==UNLOCK_COUNT -> HUNT.
  - locked = (state==LOCKED), registered.
- Wrap-around: the rotation 100..0 -> 0..001 is a valid match.
- The all-zero sample and multi-hot samples are invalid.
- err_count is cleared only by rst; it is never cleared by unlock or relock.
- Reset mid-operation returns to the reset values on the next edge, regardless of en or state.

Test Plan (WIDTH=4, LOCK_COUNT=3, UNLOCK_COUNT=2 unless stated):
1. Acquire and lock:
   - Stimulus: rst, then en=1 with samples 0001,0010,0100,1000.
   - Response: index 0,1,2,3; seq_ok 0,1,1,1; locked=1 after the 4th sample edge; err_count=0.
2. Single miss with flywheel:
   - Stimulus: locked after 1000, then samples 0011,0010,0100.
   - Response: at 0011, onehot_ok=0, err_pulse=1 for one cycle, err_count=1, locked stays 1. The predicted 0001 is taken as prev, so 0010 gives seq_ok=1 and miss_cnt clears.
3. Unlock:
   - Stimulus: locked after 0001, then samples 0100,0001.
   - Response: two misses give err_pulse on both cycles, err_count=2, locked=0 after the 2nd, state HUNT. Then 0010,0100,1000,0001 relock with err_count still 2.
4. Wrap and acquire restart:
   - Stimulus: samples 1000,0001 -> seq_ok=1. Then in ACQUIRE, 0001,0100 (valid, wrong).
   - Response: good_cnt resets, no err_pulse, locked=0; lock requires 3 further correct rotations.
5. Enable gating and mid-op reset:
   - Stimulus: locked, en=0 for 3 cycles with garbage ring_in.
   - Response: outputs held, err_pulse=0. Then rst=1 together with en=1 for one cycle gives all outputs 0 next edge.
6. Saturation:
   - Stimulus: ERR_CNT_W=2, UNLOCK_COUNT=4; lock, then 5 consecutive invalid 0000 samples.
   - Response: err_count goes 1,2,3,3 and holds at 3; the lock drops on the 4th miss.

Source files
------------

// File: rtl/ring_sequence_checker_if.sv
// Ring bus sample path and checker results.
interface ring_sequence_checker_if #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ERR_CNT_W = 8
);
   localparam int unsigned IDX_W = $clog2(WIDTH);

   logic                 en;
   logic [WIDTH-1:0]     ring_in;
   logic [IDX_W-1:0]     index;
   logic                 onehot_ok;
   logic                 seq_ok;
   logic                 locked;
   logic                 err_pulse;
   logic [ERR_CNT_W-1:0] err_count;

   // Sample source: drives the ring samples and observes the checker.
   modport master (
      output en, ring_in,
      input  index, onehot_ok, seq_ok, locked, err_pulse, err_count
   );

   // Checker side.
   modport slave (
      input  en, ring_in,
      output index, onehot_ok, seq_ok, locked, err_pulse, err_count
   );
endinterface

// File: rtl/ring_sequence_checker.sv
// Receive-side monitor for a one-hot ring counter bus: one-hot check,
// binary decode, rotation sequence check with lock/unlock and error count.
module ring_sequence_checker #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned LOCK_COUNT   = 3,
   parameter int unsigned UNLOCK_COUNT = 2,
   parameter int unsigned ERR_CNT_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   ring_sequence_checker_if.slave        bus
);
   localparam int unsigned IDX_W  = $clog2(WIDTH);
   localparam int unsigned POP_W  = $clog2(WIDTH + 1);
   localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MISS_W = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  prev;
   logic [GOOD_W-1:0] good_cnt;
   logic [MISS_W-1:0] miss_cnt;

   logic [POP_W-1:0]  pop_c;
   logic [IDX_W-1:0]  idx_c;
   logic              valid_c;
   logic              match_c;

   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], x[WIDTH-1]};
   endfunction

   // Popcount and set-bit position of the current sample.
   always_comb begin
      pop_c = '0;
      idx_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pop_c = pop_c + POP_W'(bus.ring_in[i]);
         if (bus.ring_in[i]) idx_c = IDX_W'(i);
      end
      valid_c = (pop_c == POP_W'(1));
      match_c = valid_c && (state != HUNT) && (bus.ring_in == rotl(prev));
   end

   // Sequence FSM with registered decode, lock and error outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= HUNT;
         prev          <= '0;
         good_cnt      <= '0;
         miss_cnt      <= '0;
         bus.index     <= '0;
         bus.onehot_ok <= 1'b0;
         bus.seq_ok    <= 1'b0;
         bus.locked    <= 1'b0;
         bus.err_pulse <= 1'b0;
         bus.err_count <= '0;
      end else begin
         bus.err_pulse <= 1'b0;
         if (bus.en) begin
            bus.index     <= valid_c ? idx_c : '0;
            bus.onehot_ok <= valid_c;
            bus.seq_ok    <= match_c;
            case (state)
               HUNT: begin
                  if (valid_c) begin
                     state    <= ACQUIRE;
                     prev     <= bus.ring_in;
                     good_cnt <= '0;
                  end
                  bus.locked <= 1'b0;
               end
               ACQUIRE: begin
                  bus.locked <= 1'b0;
                  if (match_c) begin
                     prev     <= bus.ring_in;
                     good_cnt <= good_cnt + GOOD_W'(1);
                     if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                        state      <= LOCKED;
                        miss_cnt   <= '0;
                        bus.locked <= 1'b1;
                     end
                  end else if (valid_c) begin
                     // Valid but out of order: restart acquisition from here.
                     prev     <= bus.ring_in;
                     good_cnt <= '0;
                  end else begin
                     state <= HUNT;
                  end
               end
               LOCKED: begin
                  bus.locked <= 1'b1;
                  if (match_c) begin
                     miss_cnt <= '0;
                     prev     <= bus.ring_in;
                  end else begin
                     bus.err_pulse <= 1'b1;
                     if (bus.err_count != '1) bus.err_count <= bus.err_count + ERR_CNT_W'(1);
                     miss_cnt <= miss_cnt + MISS_W'(1);
                     // Flywheel on invalid samples keeps the expected sequence advancing.
                     prev <= valid_c ? bus.ring_in : rotl(prev);
                     if (miss_cnt == MISS_W'(UNLOCK_COUNT - 1)) begin
                        state      <= HUNT;
                        bus.locked <= 1'b0;
                     end
                  end
               end
               default: begin
                  state      <= HUNT;
                  bus.locked <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed, table-driven bench for ring_sequence_checker.
module tb_ring_sequence_checker;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Main instance: WIDTH=4, LOCK_COUNT=3, UNLOCK_COUNT=2, ERR_CNT_W=8.
   ring_sequence_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus_a ();
   ring_sequence_checker #(
      .WIDTH(4), .LOCK_COUNT(3), .UNLOCK_COUNT(2), .ERR_CNT_W(8)
   ) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a.slave)
   );

   // Saturation instance: ERR_CNT_W=2, UNLOCK_COUNT=4.
   ring_sequence_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) bus_b ();
   ring_sequence_checker #(
      .WIDTH(4), .LOCK_COUNT(3), .UNLOCK_COUNT(4), .ERR_CNT_W(2)
   ) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b.slave)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] ring;
      logic [1:0] idx;
      logic       ok;
      logic       sq;
      logic       lk;
      logic       ep;
      logic [7:0] ec;
   } vec_t;

   vec_t tv[$];

   task automatic addv(input logic r, input logic e, input logic [3:0] ring,
                       input logic [1:0] idx, input logic ok, input logic sq,
                       input logic lk, input logic ep, input logic [7:0] ec);
      vec_t v;
      v.rst = r; v.en = e; v.ring = ring; v.idx = idx; v.ok = ok;
      v.sq = sq; v.lk = lk; v.ep = ep; v.ec = ec;
      tv.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic step_b(input logic e, input logic [3:0] ring);
      bus_b.en      = e;
      bus_b.ring_in = ring;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.en = 1'b0; bus_a.ring_in = '0;
      bus_b.en = 1'b0; bus_b.ring_in = '0;

      //    rst  en  ring     idx ok sq lk ep ec
      addv(1'b1, 1, 4'b0000, 0, 0, 0, 0, 0, 0);   // reset
      // acquire and lock
      addv(1'b0, 1, 4'b0001, 0, 1, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b0010, 1, 1, 1, 0, 0, 0);
      addv(1'b0, 1, 4'b0100, 2, 1, 1, 0, 0, 0);
      addv(1'b0, 1, 4'b1000, 3, 1, 1, 1, 0, 0);
      // single invalid miss, flywheel predicts 0001
      addv(1'b0, 1, 4'b0011, 0, 0, 0, 1, 1, 1);
      addv(1'b0, 1, 4'b0010, 1, 1, 1, 1, 0, 1);
      addv(1'b0, 1, 4'b0100, 2, 1, 1, 1, 0, 1);
      addv(1'b0, 1, 4'b1000, 3, 1, 1, 1, 0, 1);
      addv(1'b0, 1, 4'b0001, 0, 1, 1, 1, 0, 1);   // wrap while locked
      // two valid misses unlock
      addv(1'b0, 1, 4'b0100, 2, 1, 0, 1, 1, 2);
      addv(1'b0, 1, 4'b0001, 0, 1, 0, 0, 1, 3);
      // relock, err_count retained
      addv(1'b0, 1, 4'b0010, 1, 1, 0, 0, 0, 3);
      addv(1'b0, 1, 4'b0100, 2, 1, 1, 0, 0, 3);
      addv(1'b0, 1, 4'b1000, 3, 1, 1, 0, 0, 3);
      addv(1'b0, 1, 4'b0001, 0, 1, 1, 1, 0, 3);
      // reset, then wrap in ACQUIRE and acquisition restart
      addv(1'b1, 1, 4'b0010, 0, 0, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b1000, 3, 1, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b0001, 0, 1, 1, 0, 0, 0);
      addv(1'b0, 1, 4'b0001, 0, 1, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b0100, 2, 1, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b1000, 3, 1, 1, 0, 0, 0);
      addv(1'b0, 1, 4'b0001, 0, 1, 1, 0, 0, 0);
      addv(1'b0, 1, 4'b0010, 1, 1, 1, 1, 0, 0);
      // miss, then enable gating holds everything but err_pulse
      addv(1'b0, 1, 4'b0011, 0, 0, 0, 1, 1, 1);
      addv(1'b0, 0, 4'b1111, 0, 0, 0, 1, 0, 1);
      addv(1'b0, 0, 4'b0000, 0, 0, 0, 1, 0, 1);
      addv(1'b0, 0, 4'b0110, 0, 0, 0, 1, 0, 1);
      addv(1'b0, 1, 4'b1000, 3, 1, 1, 1, 0, 1);   // flywheel predicted 0100
      // mid-op reset has priority over en
      addv(1'b1, 1, 4'b0001, 0, 0, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b0110, 0, 0, 0, 0, 0, 0);
      addv(1'b0, 1, 4'b0100, 2, 1, 0, 0, 0, 0);

      for (int i = 0; i < tv.size(); i++) begin
         rst_a         = tv[i].rst;
         bus_a.en      = tv[i].en;
         bus_a.ring_in = tv[i].ring;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.index", i),     32'(bus_a.index),     32'(tv[i].idx));
         chk($sformatf("v%0d.onehot_ok", i), 32'(bus_a.onehot_ok), 32'(tv[i].ok));
         chk($sformatf("v%0d.seq_ok", i),    32'(bus_a.seq_ok),    32'(tv[i].sq));
         chk($sformatf("v%0d.locked", i),    32'(bus_a.locked),    32'(tv[i].lk));
         chk($sformatf("v%0d.err_pulse", i), 32'(bus_a.err_pulse), 32'(tv[i].ep));
         chk($sformatf("v%0d.err_count", i), 32'(bus_a.err_count), 32'(tv[i].ec));
      end
      bus_a.en = 1'b0;

      // Saturation of a 2-bit error counter with UNLOCK_COUNT=4.
      rst_b = 1'b1;
      step_b(1'b1, 4'b0001);
      chk("sat.reset_count", 32'(bus_b.err_count), 32'd0);
      rst_b = 1'b0;
      step_b(1'b1, 4'b0001);
      step_b(1'b1, 4'b0010);
      step_b(1'b1, 4'b0100);
      chk("sat.not_yet_locked", 32'(bus_b.locked), 32'd0);
      step_b(1'b1, 4'b1000);
      chk("sat.locked", 32'(bus_b.locked), 32'd1);
      begin
         logic [1:0] exp_ec [5];
         logic       exp_ep [5];
         logic       exp_lk [5];
         exp_ec = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
         exp_ep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         exp_lk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
         for (int k = 0; k < 5; k++) begin
            step_b(1'b1, 4'b0000);
            chk($sformatf("sat%0d.err_count", k), 32'(bus_b.err_count), 32'(exp_ec[k]));
            chk($sformatf("sat%0d.err_pulse", k), 32'(bus_b.err_pulse), 32'(exp_ep[k]));
            chk($sformatf("sat%0d.locked", k),    32'(bus_b.locked),    32'(exp_lk[k]));
            chk($sformatf("sat%0d.onehot_ok", k), 32'(bus_b.onehot_ok), 32'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
